fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Control end of the EX-stage operand forwarding muxes in the 5-stage MIPS pipeline. Generates the 2-bit select codes those muxes consume.
- Keeps its own shadow pipeline (ID/EX, EX/MEM, MEM/WB) of destination register, RegWrite and MemRead.
- Resolves RAW hazards by forwarding, or by a one-cycle load-use stall with bubble insertion.
- Keeps a saturating stall counter for performance debug.

Parameters:
- REG_W, 5, register-specifier width
- CNT_W, 16, stall-counter width

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  synchronous reset, active-high
- ID_Valid  in  1  instruction present in ID
- ID_Rs  in  REG_W  ID source register 1
- ID_Rt  in  REG_W  ID source register 2
- ID_Dest  in  REG_W  ID destination register, already resolved Rt/Rd/31
- ID_RegWrite  in  1  ID instruction writes the register file
- ID_MemRead  in  1  ID instruction is a load
- Flush  in  1  branch taken; squash the instruction entering EX
- FwdA  out  2  select for EX operand A mux
- FwdB  out  2  select for EX operand B mux
- Stall  out  1  hold PC and IF/ID this cycle
- StallCnt  out  CNT_W  number of stall cycles, saturating

Behaviour:
- Select encoding (fixed, matches the mux input order):
  - 00 = register-file value
  - 01 = MEM/WB write-back result
  - 10 = EX/MEM ALU result
  - 11 = never driven
- Shadow stages: EX{V,Rs,Rt,Dest,RW,MR}, MEM{V,Dest,RW}, WB{V,Dest,RW}. All advance every rising Clk edge; nothing in this block is held.
  - EX loads the ID fields with V = ID_Valid & ~Stall & ~Flush. When Stall or Flush is set, EX.V=0, which is the bubble.
  - MEM takes EX. WB takes MEM.
- FwdA is combinational from registered state:
  - 10 if MEM.V & MEM.RW & MEM.Dest!=0 & MEM.Dest==EX.Rs
  - else 01 if WB.V & WB.RW & WB.Dest!=0 & WB.Dest==EX.Rs
  - else 00
  - MEM has priority over WB.
- FwdB: same rules using EX.Rt.
- Stall (combinational) = ID_Valid & EX.V & EX.MR & EX.Dest!=0 & (EX.Dest==ID_Rs | EX.Dest==ID_Rt).
  - Exactly one stall cycle per load-use pair.
  - Next cycle EX holds a bubble, so Stall drops.
  - The consumer later sees the load in WB and gets Fwd=01.
- Stall and Flush in the same cycle: the bubble is inserted once and Stall is still asserted.
- Register $0 is never a forwarding or stall source.
- StallCnt:
  - Increments by 1 on each edge where Stall=1.
  - Saturates at all-ones; no wrap.
- Reset:
  - On a Clk edge with Rst=1, all V bits and StallCnt clear, and all fields go to 0.
  - After that edge: FwdA=FwdB=00, Stall=0, StallCnt=0.
  - Rst mid-stall or mid-flush discards all in-flight state. Rst has priority over Flush and Stall.
- Latency:
  - ID inputs reach the EX shadow 1 cycle later, MEM 2 cycles later, WB 3 cycles later.
  - Fwd outputs are valid in the same cycle as the corresponding EX instruction.

Test Plan:
- Hold Rst for 2 cycles with arbitrary inputs -> FwdA=FwdB=00, Stall=0, StallCnt=0 after the reset edge.
- Issue add $3 (Dest=3, RW=1), then sub Rs=3, Rt=4 next cycle -> when sub is in EX: FwdA=10, FwdB=00.
- add $3; nop; or Rs=5, Rt=3 -> when or is in EX: FwdA=00, FwdB=01.
- lw $7 (MR=1, RW=1), then and Rs=7 -> Stall=1 for exactly 1 cycle and StallCnt=1. The next cycle EX holds a bubble. When and reaches EX: FwdA=01.
- Writer with Dest=0 followed by reader Rs=0 -> FwdA=00 and Stall=0. Double hazard (MEM.Dest=WB.Dest=9, EX.Rs=9) -> FwdA=10.
- Flush asserted with the lw of the load-use pair in ID -> no stall follows. Also: force a stall every cycle with StallCnt preset near max (CNT_W=4 in a test instance) -> StallCnt sticks at 15.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding-select and load-use hazard control.
// Keeps a shadow ID/EX, EX/MEM, MEM/WB pipeline of write-back controls.
module fwd_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             ID_Valid,
    input  logic [REG_W-1:0] ID_Rs,
    input  logic [REG_W-1:0] ID_Rt,
    input  logic [REG_W-1:0] ID_Dest,
    input  logic             ID_RegWrite,
    input  logic             ID_MemRead,
    input  logic             Flush,
    output logic [1:0]       FwdA,
    output logic [1:0]       FwdB,
    output logic             Stall,
    output logic [CNT_W-1:0] StallCnt
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    localparam logic [REG_W-1:0] ZERO_REG = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // EX shadow stage
    logic             r_ex_v;
    logic [REG_W-1:0] r_ex_rs;
    logic [REG_W-1:0] r_ex_rt;
    logic [REG_W-1:0] r_ex_dest;
    logic             r_ex_rw;
    logic             r_ex_mr;

    // MEM shadow stage
    logic             r_mem_v;
    logic [REG_W-1:0] r_mem_dest;
    logic             r_mem_rw;

    // WB shadow stage
    logic             r_wb_v;
    logic [REG_W-1:0] r_wb_dest;
    logic             r_wb_rw;

    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_mem_src;
    logic             w_wb_src;
    logic             w_ex_load;
    logic             w_stall;
    logic             w_ex_v_nxt;
    logic             w_cnt_sat;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;

    // Which older stages can legally source a forwarded value ($0 never can)
    always_comb begin
        w_mem_src = r_mem_v & r_mem_rw & (r_mem_dest != ZERO_REG);
        w_wb_src  = r_wb_v & r_wb_rw & (r_wb_dest != ZERO_REG);
        w_ex_load = r_ex_v & r_ex_mr & (r_ex_dest != ZERO_REG);
    end

    // Operand A select: the younger MEM result wins over WB
    always_comb begin
        w_fwd_a = SEL_RF;
        if (w_mem_src && (r_mem_dest == r_ex_rs)) begin
            w_fwd_a = SEL_MEM;
        end else if (w_wb_src && (r_wb_dest == r_ex_rs)) begin
            w_fwd_a = SEL_WB;
        end
    end

    // Operand B select: same priority, keyed on Rt
    always_comb begin
        w_fwd_b = SEL_RF;
        if (w_mem_src && (r_mem_dest == r_ex_rt)) begin
            w_fwd_b = SEL_MEM;
        end else if (w_wb_src && (r_wb_dest == r_ex_rt)) begin
            w_fwd_b = SEL_WB;
        end
    end

    // Load in EX feeding the ID instruction cannot be forwarded in time
    always_comb begin
        w_stall    = ID_Valid & w_ex_load &
                     ((r_ex_dest == ID_Rs) | (r_ex_dest == ID_Rt));
        w_ex_v_nxt = ID_Valid & ~w_stall & ~Flush;
        w_cnt_sat  = &r_stall_cnt;
    end

    // Shadow pipeline advances every edge; stall or flush injects a bubble
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ex_v     <= 1'b0;
            r_ex_rs    <= '0;
            r_ex_rt    <= '0;
            r_ex_dest  <= '0;
            r_ex_rw    <= 1'b0;
            r_ex_mr    <= 1'b0;
            r_mem_v    <= 1'b0;
            r_mem_dest <= '0;
            r_mem_rw   <= 1'b0;
            r_wb_v     <= 1'b0;
            r_wb_dest  <= '0;
            r_wb_rw    <= 1'b0;
        end else begin
            r_ex_v     <= w_ex_v_nxt;
            r_ex_rs    <= ID_Rs;
            r_ex_rt    <= ID_Rt;
            r_ex_dest  <= ID_Dest;
            r_ex_rw    <= ID_RegWrite;
            r_ex_mr    <= ID_MemRead;
            r_mem_v    <= r_ex_v;
            r_mem_dest <= r_ex_dest;
            r_mem_rw   <= r_ex_rw;
            r_wb_v     <= r_mem_v;
            r_wb_dest  <= r_mem_dest;
            r_wb_rw    <= r_mem_rw;
        end
    end

    // Saturating count of stall cycles
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !w_cnt_sat) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

    assign FwdA     = w_fwd_a;
    assign FwdB     = w_fwd_b;
    assign Stall    = w_stall;
    assign StallCnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: history-based reference model,
// directed hazard scenarios followed by random instruction streams.
module tb_fwd_hazard_ctrl;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       ID_Valid = 1'b0;
    logic [4:0] ID_Rs = '0;
    logic [4:0] ID_Rt = '0;
    logic [4:0] ID_Dest = '0;
    logic       ID_RegWrite = 1'b0;
    logic       ID_MemRead = 1'b0;
    logic       Flush = 1'b0;

    logic [1:0]  FwdA, FwdB, FwdA_s, FwdB_s;
    logic        Stall, Stall_s;
    logic [15:0] StallCnt;
    logic [3:0]  StallCnt_s;

    always #5 Clk = ~Clk;

    fwd_hazard_ctrl dut (
        .Clk(Clk), .Rst(Rst), .ID_Valid(ID_Valid),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Dest(ID_Dest),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
        .Flush(Flush), .FwdA(FwdA), .FwdB(FwdB),
        .Stall(Stall), .StallCnt(StallCnt)
    );

    fwd_hazard_ctrl #(.REG_W(5), .CNT_W(4)) dut_s (
        .Clk(Clk), .Rst(Rst), .ID_Valid(ID_Valid),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Dest(ID_Dest),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
        .Flush(Flush), .FwdA(FwdA_s), .FwdB(FwdB_s),
        .Stall(Stall_s), .StallCnt(StallCnt_s)
    );

    typedef struct {
        bit v;
        int rs;
        int rt;
        int dest;
        bit rw;
        bit mr;
    } instr_t;

    typedef struct {
        int fa;
        int fb;
        int st;
        int cnt;
        int cnt_s;
    } exp_t;

    // hist[0] = instruction in EX, hist[1] = MEM, hist[2] = WB
    instr_t hist[$];
    int     stalls_total;
    exp_t   sbq[$];
    int     n_checks = 0;
    int     n_pass = 0;
    int     n_stall_seen = 0;

    function automatic instr_t bubble();
        instr_t b;
        b.v = 0; b.rs = 0; b.rt = 0; b.dest = 0; b.rw = 0; b.mr = 0;
        return b;
    endfunction

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back(bubble());
        stalls_total = 0;
    endfunction

    // Nearest older producer of src wins: 2 = from MEM, 1 = from WB
    function automatic int exp_fwd(int src);
        for (int age = 1; age <= 2; age++) begin
            if (hist[age].v && hist[age].rw && hist[age].dest != 0 &&
                hist[age].dest == src)
                return (age == 1) ? 2 : 1;
        end
        return 0;
    endfunction

    function automatic int exp_stall(bit v, int rs, int rt);
        instr_t e;
        e = hist[0];
        return (v && e.v && e.mr && e.dest != 0 &&
                (e.dest == rs || e.dest == rt)) ? 1 : 0;
    endfunction

    function automatic int sat(int x, int mx);
        return (x > mx) ? mx : x;
    endfunction

    task automatic check(string name, int act, int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      name, act, req, $time);
    endtask

    // One cycle: apply inputs, predict outputs, then advance model at edge
    task automatic step(bit v, int rs, int rt, int dest, bit rw, bit mr,
                        bit fl, bit rst);
        exp_t   e;
        instr_t n;
        int     st;
        ID_Valid = v;
        ID_Rs = rs[4:0];
        ID_Rt = rt[4:0];
        ID_Dest = dest[4:0];
        ID_RegWrite = rw;
        ID_MemRead = mr;
        Flush = fl;
        Rst = rst;
        st = exp_stall(v, rs, rt);
        if (!rst) begin
            e.fa = exp_fwd(hist[0].rs);
            e.fb = exp_fwd(hist[0].rt);
            e.st = st;
            e.cnt = sat(stalls_total, 65535);
            e.cnt_s = sat(stalls_total, 15);
            sbq.push_back(e);
        end
        @(posedge Clk);
        if (rst) begin
            model_reset();
        end else begin
            n.v = v && st == 0 && !fl;
            n.rs = rs; n.rt = rt; n.dest = dest;
            n.rw = rw; n.mr = mr;
            hist.push_front(n);
            void'(hist.pop_back());
            stalls_total += st;
        end
        #1;
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare every presented output against the queued prediction
    always @(negedge Clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("FwdA", int'(FwdA), e.fa);
            check("FwdB", int'(FwdB), e.fb);
            check("Stall", int'(Stall), e.st);
            check("StallCnt", int'(StallCnt), e.cnt);
            check("FwdA_s", int'(FwdA_s), e.fa);
            check("Stall_s", int'(Stall_s), e.st);
            check("StallCnt_s", int'(StallCnt_s), e.cnt_s);
            if (e.st != 0) n_stall_seen++;
        end
    end

    initial begin
        model_reset();
        @(posedge Clk);
        #1;
        // reset held two cycles with arbitrary inputs
        step(1, 3, 7, 7, 1, 1, 1, 1);
        step(1, 9, 2, 4, 1, 0, 0, 1);
        nop();
        // add $3 ; sub rs=3 rt=4 -> A from MEM
        step(1, 1, 2, 3, 1, 0, 0, 0);
        step(1, 3, 4, 5, 1, 0, 0, 0);
        nop(); nop(); nop();
        // add $3 ; nop ; or rs=5 rt=3 -> B from WB
        step(1, 1, 2, 3, 1, 0, 0, 0);
        nop();
        step(1, 5, 3, 6, 1, 0, 0, 0);
        nop(); nop(); nop();
        // lw $7 ; and rs=7 (held while stalled)
        step(1, 1, 0, 7, 1, 1, 0, 0);
        step(1, 7, 8, 10, 1, 0, 0, 0);
        step(1, 7, 8, 10, 1, 0, 0, 0);
        nop(); nop(); nop();
        // $0 writer, $0 reader: no forwarding, no stall
        step(1, 1, 1, 0, 1, 1, 0, 0);
        step(1, 0, 0, 2, 1, 0, 0, 0);
        nop(); nop(); nop();
        // double hazard on $9
        step(1, 1, 2, 9, 1, 0, 0, 0);
        step(1, 1, 2, 9, 1, 0, 0, 0);
        step(1, 9, 9, 11, 1, 0, 0, 0);
        nop(); nop(); nop();
        // flushed load: consumer must not stall
        step(1, 1, 0, 7, 1, 1, 1, 0);
        step(1, 7, 7, 12, 1, 0, 0, 0);
        nop(); nop(); nop();
        // stall together with flush
        step(1, 1, 0, 7, 1, 1, 0, 0);
        step(1, 7, 0, 12, 1, 0, 1, 0);
        step(1, 7, 0, 12, 1, 0, 0, 0);
        nop();
        // reset in the middle of a stall
        step(1, 1, 0, 6, 1, 1, 0, 0);
        step(1, 6, 0, 12, 1, 0, 0, 1);
        step(1, 6, 0, 12, 1, 0, 0, 0);
        nop(); nop(); nop();
        // back-to-back load-use pairs to saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 2, 8, 1, 1, 0, 0);
            step(1, 8, 3, 4, 1, 0, 0, 0);
        end
        // random streams over a small register set
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
        end
        nop();
        for (int i = 0; i < 4 && sbq.size() > 0; i++) @(negedge Clk);
        #1;
        if (sbq.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d predictions left, expected 0",
                     sbq.size());
        end
        n_checks++;
        if (n_stall_seen >= 20) n_pass++;
        else $display("FAIL stall_coverage: got %0d stalls expected >= 20",
                      n_stall_seen);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
